// File: rtl/conv_frame_ctrl_if.sv
// Handshake and code-stream bundle for the K=3 rate-1/2 convolutional frame controller.
// The master modport is the source/sink side; the slave modport is the controller.
interface conv_frame_ctrl_if;
   logic start;
   logic abort;
   logic src_valid;
   logic src_bit;
   logic src_ready;
   logic code_bit;
   logic code_valid;
   logic code_last;
   logic busy;
   logic frame_done;

   modport master (
      output start,
      output abort,
      output src_valid,
      output src_bit,
      input  src_ready,
      input  code_bit,
      input  code_valid,
      input  code_last,
      input  busy,
      input  frame_done
   );

   modport slave (
      input  start,
      input  abort,
      input  src_valid,
      input  src_bit,
      output src_ready,
      output code_bit,
      output code_valid,
      output code_last,
      output busy,
      output frame_done
   );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame controller for a K=3, rate-1/2 convolutional encoder (g1=111, g2=101).
// Each info bit is emitted as c1 then c2; every frame ends with two zero flush bits.
module conv_frame_ctrl #(
   parameter int FRAME_LEN = 8   // info bits per frame, legal 1..255
) (
   input logic              clk,
   input logic              rst,
   conv_frame_ctrl_if.slave bus
);

   localparam int         TAIL_LEN     = 2;
   localparam logic [7:0] FRAME_LEN_W  = 8'(FRAME_LEN);
   localparam logic [1:0] TAIL_LEN_W   = 2'(TAIL_LEN);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EMIT0,
      EMIT1,
      FLUSH,
      DONE
   } state_t;

   state_t     state;
   state_t     state_next;

   logic [1:0] sr;
   logic       c1;
   logic       c2;
   logic [7:0] info_cnt;
   logic [1:0] tail_cnt;

   logic       accept;
   logic       inject;
   logic       clear_frame;
   logic       u;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort overrides every transition and also suppresses any bit consumption.
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      inject      = 1'b0;
      clear_frame = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next  = FETCH;
               clear_frame = 1'b1;
            end
         end
         FETCH: begin
            if (bus.src_valid) begin
               accept     = 1'b1;
               state_next = EMIT0;
            end
         end
         EMIT0: begin
            state_next = EMIT1;
         end
         EMIT1: begin
            if (info_cnt < FRAME_LEN_W) begin
               state_next = FETCH;
            end else if (tail_cnt < TAIL_LEN_W) begin
               state_next = FLUSH;
            end else begin
               state_next = DONE;
            end
         end
         FLUSH: begin
            inject     = 1'b1;
            state_next = EMIT0;
         end
         DONE: begin
            clear_frame = 1'b1;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (bus.abort) begin
         state_next  = IDLE;
         accept      = 1'b0;
         inject      = 1'b0;
         clear_frame = 1'b1;
      end
   end

   assign u = accept ? bus.src_bit : 1'b0;

   // sr[0] holds the previous input (u1), sr[1] the one before it (u2).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr       <= 2'b00;
         c1       <= 1'b0;
         c2       <= 1'b0;
         info_cnt <= 8'd0;
         tail_cnt <= 2'd0;
      end else if (clear_frame) begin
         sr       <= 2'b00;
         c1       <= 1'b0;
         c2       <= 1'b0;
         info_cnt <= 8'd0;
         tail_cnt <= 2'd0;
      end else if (accept || inject) begin
         c1 <= u ^ sr[0] ^ sr[1];
         c2 <= u ^ sr[1];
         sr <= {sr[0], u};
         if (accept) begin
            info_cnt <= info_cnt + 8'd1;
         end else begin
            tail_cnt <= tail_cnt + 2'd1;
         end
      end
   end

   assign bus.src_ready  = (state == FETCH) && !bus.abort;
   assign bus.code_valid = (state == EMIT0) || (state == EMIT1);
   assign bus.code_bit   = (state == EMIT0) ? c1 :
                           (state == EMIT1) ? c2 : 1'b0;
   assign bus.code_last  = (state == EMIT1) && (tail_cnt == TAIL_LEN_W);
   assign bus.busy       = (state != IDLE);
   assign bus.frame_done = (state == DONE) && !bus.abort;

endmodule
